mem_bus_arbiter: RTL

//   Shares one single-port memory between the core's instruction-fetch port and its data load/store port.
//   One transaction in flight at a time: grant, issue, fixed-latency wait, response.

---
 rtl/mem_bus_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data ports.
// One transaction in flight: grant, issue, fixed-latency wait, response.
module mem_bus_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_LATENCY    = 2,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_req,
    input  logic [DATA_WIDTH-1:0]   i_addr,
    output logic                    i_gnt,
    output logic                    i_rvalid,
    output logic [DATA_WIDTH-1:0]   i_rdata,

    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,

    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int unsigned WaitW  = $clog2(MEM_LATENCY + 1);
    localparam int unsigned BurstW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [WaitW-1:0]  WaitLoad = WaitW'(MEM_LATENCY);
    localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_DATA_BURST);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                  state_q, state_d;
    logic [WaitW-1:0]        wait_q, wait_d;
    logic [BurstW-1:0]       burst_q, burst_d;
    logic                    owner_q;  // 1 = data port owns the transaction
    logic                    fetch_win, data_win, last_wait;

    logic                    mem_we_q;
    logic [DATA_WIDTH-1:0]   mem_addr_q, mem_wdata_q;
    logic [DATA_WIDTH/8-1:0] mem_be_q;
    logic [DATA_WIDTH-1:0]   i_rdata_q, d_rdata_q;

    // Fetch wins when alone, or when the data burst limit has been reached.
    always_comb begin
        fetch_win = 1'b0;
        data_win  = 1'b0;
        if (state_q == StIdle && !rst) begin
            if (i_req && (!d_req || burst_q == BurstMax)) begin
                fetch_win = 1'b1;
            end else if (d_req) begin
                data_win = 1'b1;
            end
        end
    end

    assign last_wait = (state_q == StWait) && (wait_q == WaitW'(1));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        burst_d = burst_q;
        unique case (state_q)
            StIdle: begin
                if (fetch_win) begin
                    state_d = StIssue;
                    burst_d = '0;
                end else if (data_win) begin
                    state_d = StIssue;
                    if (!i_req) begin
                        burst_d = '0;
                    end else if (burst_q != BurstMax) begin
                        burst_d = burst_q + BurstW'(1);
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
                wait_d  = WaitLoad;
            end
            StWait: begin
                wait_d = wait_q - WaitW'(1);
                if (last_wait) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wait_q      <= '0;
            burst_q     <= '0;
            owner_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            burst_q <= burst_d;

            if (fetch_win) begin
                owner_q     <= 1'b0;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= i_addr;
                mem_wdata_q <= '0;
                mem_be_q    <= '1;
            end else if (data_win) begin
                owner_q     <= 1'b1;
                mem_we_q    <= d_we;
                mem_addr_q  <= d_addr;
                mem_wdata_q <= d_wdata;
                mem_be_q    <= d_we ? d_be : '1;
            end else if (state_q == StResp) begin
                mem_we_q    <= 1'b0;
                mem_addr_q  <= '0;
                mem_wdata_q <= '0;
                mem_be_q    <= '0;
            end

            if (last_wait) begin
                if (owner_q) begin
                    d_rdata_q <= mem_we_q ? '0 : mem_rdata;
                end else begin
                    i_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign i_gnt     = fetch_win;
    assign d_gnt     = data_win;
    assign mem_req   = (state_q == StIssue);
    assign i_rvalid  = (state_q == StResp) && !owner_q;
    assign d_rvalid  = (state_q == StResp) && owner_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule
